// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_buffer
//  Description : Two-entry registered skid buffer between CPU pipeline stages.
//                Valid/ready on both sides and 1 transfer/cycle. The head
//                entry, OutValid and the state behind InReady are all
//                registered. A synchronous flush squashes buffered entries.
//                Optional macro SKID_STALL_COUNT_EN builds a 32-bit counter
//                of output stall cycles (OutValid && !OutReady) on o_stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_stalls
);

    // Occupancy state: number of entries held (main only, or main + skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;

    logic             w_acc;
    logic             w_take;

    // Ready depends only on registered state, gated by flush so nothing is
    // accepted in the squash cycle.
    assign o_in_ready  = !i_flush && (r_state != ST_TWO);
    assign w_acc       = i_in_valid && o_in_ready;
    assign w_take      = r_out_valid && i_out_ready;

    assign o_out_data  = r_main;
    assign o_out_valid = r_out_valid;

    // Occupancy FSM with data movement; reset beats flush, flush beats traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
        end else if (i_flush) begin
            // Data registers keep stale contents; only occupancy is cleared.
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_main      <= i_in_data;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_take) begin
                        // Head leaves while new entry arrives: full throughput.
                        r_main <= i_in_data;
                    end else if (w_acc) begin
                        // Consumer stalled: park the new entry behind the head.
                        r_skid  <= i_in_data;
                        r_state <= ST_TWO;
                    end else if (w_take) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_take) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SKID_STALL_COUNT_EN
    logic [31:0] r_stalls;

    // Count cycles where the head is offered but not taken; flush does not clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stalls <= '0;
        end else if (r_out_valid && !i_out_ready) begin
            r_stalls <= r_stalls + 32'd1;
        end
    end

    assign o_stalls = r_stalls;
`else
    assign o_stalls = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_buffer
//  Description : Scoreboard bench for pipe_skid_buffer. The driver pushes
//                every accepted word into an expected-order queue; a monitor
//                compares the head, OutValid, InReady and the stall counter
//                against that queue every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buffer;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         i_flush;
    logic [W-1:0] i_in_data;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [W-1:0] o_out_data;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [31:0]  o_stalls;

    int checks   = 0;
    int failures = 0;

    // Expected contents of the buffer, oldest first
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_stalls = 32'd0;

    pipe_skid_buffer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (i_flush),
        .i_in_data  (i_in_data),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .o_out_data (o_out_data),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_stalls   (o_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare DUT outputs with the model between clock edges
    always @(negedge clk) begin
        if (rst) begin
            m_stalls = 32'd0;
        end else begin
            chk("out_valid", {31'd0, o_out_valid}, {31'd0, exp_q.size() != 0});
            chk("in_ready", {31'd0, o_in_ready}, {31'd0, !i_flush && exp_q.size() < 2});
`ifdef SKID_STALL_COUNT_EN
            chk("stalls", o_stalls, m_stalls);
`else
            chk("stalls_tied", o_stalls, 32'd0);
`endif
            if (o_out_valid && exp_q.size() != 0) begin
                chk("out_data", o_out_data, exp_q[0]);
                if (i_out_ready) void'(exp_q.pop_front());
            end
            if (o_out_valid && !i_out_ready) m_stalls = m_stalls + 32'd1;
        end
    end

    // One clock of stimulus; model update happens at the active edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                        input logic f, input logic rs);
        logic acc;
        i_in_valid  = v;
        i_in_data   = d;
        i_out_ready = r;
        i_flush     = f;
        rst         = rs;
        @(negedge clk);
        acc = v && o_in_ready && !rs && !f;
        @(posedge clk);
        if (rs || f) exp_q.delete();
        else if (acc) exp_q.push_back(d);
        #1;
    endtask

    // Producer that holds a word until it is accepted (bounded)
    task automatic push_hold(input logic [W-1:0] d, input logic r);
        int n = 0;
        logic done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = o_in_ready;
            @(posedge clk);
            #1;
            step(1'b1, d, r, 1'b0, 1'b0);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=%0d required=accept", n);
        end
    endtask

    initial begin
        i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
        i_flush = 1'b0; rst = 1'b1;
        @(posedge clk); #1;

        // Reset then stream
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_out_data", o_out_data, 32'd0);
        chk("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        step(1, 32'h11, 1, 0, 0);
        chk("stream_first", o_out_data, 32'h11);
        step(1, 32'h22, 1, 0, 0);
        step(1, 32'h33, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Backpressure fill: A and B accepted, C held by producer
        step(1, 32'hA, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0);
        chk("fill_ready_low", {31'd0, o_in_ready}, 32'd0);
        chk("fill_head", o_out_data, 32'hA);
        step(1, 32'hC, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0);
        chk("fill_head_stable", o_out_data, 32'hA);
        // Drain: C goes in once ready returns
        step(1, 32'hC, 1, 0, 0);
        chk("drain_ready_back", {31'd0, o_in_ready}, 32'd1);
        step(1, 32'hC, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Flush while two entries held; 0x7 is offered during the flush
        step(1, 32'h5, 0, 0, 0);
        step(1, 32'h6, 0, 0, 0);
        step(1, 32'h7, 1, 1, 0);
        chk("flush_valid", {31'd0, o_out_valid}, 32'd0);
        step(1, 32'h8, 0, 0, 0);
        chk("after_flush_head", o_out_data, 32'h8);
        step(0, 0, 1, 0, 0);

        // Reset with flush and valid together
        step(1, 32'h9, 0, 0, 0);
        step(1, 32'hD, 0, 1, 1);
        chk("rstpri_valid", {31'd0, o_out_valid}, 32'd0);
        chk("rstpri_data", o_out_data, 32'd0);

        // Stall run: one entry held for five unready cycles, then flush
        step(1, 32'hE, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        push_hold(32'hF0F0, 1);
        step(0, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom,
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 199) < 1));
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Downstream-facing counterpart to the plain enabled pipeline register: a two-entry registered skid buffer between CPU pipeline stages.
- The producer pushes with a valid/ready handshake. The consumer drains in order and may stall by dropping ready.
- Sustains 1 transfer/cycle with every output registered and InReady driven from a register (no combinational ready path through the stage), plus a flush for branch/exception squash.

Parameters:
- width, 32, data bits per entry (instruction/operand bundle width)

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Flush  input  1  synchronous squash of all buffered entries
- InData  input  width  producer data
- InValid  input  1  producer offers InData this cycle
- InReady  output  1  buffer accepts this cycle; transfer when InValid && InReady
- Output  output  width  head entry data (registered)
- OutValid  output  1  Output holds a valid entry
- OutReady  input  1  consumer takes head; transfer when OutValid && OutReady
- Stalls  output  32  stall-cycle count (only with SKID_STALL_COUNT_EN)

Behaviour:
- Storage: main register (drives Output) and skid register, plus state EMPTY / ONE / TWO.
- Signal definitions:
  - OutValid = (state != EMPTY), registered.
  - InReady = !Flush && state_reg != TWO, where state_reg is registered.
- acc = InValid && InReady; take = OutValid && OutReady.
- Reset (highest priority): state=EMPTY, Output=0, skid=0, OutValid=0. InReady=1 from the first cycle after Reset deasserts.
- Flush (priority below Reset): state=EMPTY next cycle.
  - Entries are discarded; InReady=0 during Flush, so no input is accepted that cycle.
  - Data registers hold their stale values.
- EMPTY:
  - acc -> main<=InData, go ONE.
  - Otherwise stay.
- ONE:
  - acc && take -> main<=InData, stay ONE (full throughput).
  - acc && !take -> skid<=InData, go TWO.
  - !acc && take -> go EMPTY.
  - Neither -> hold.
- TWO (InReady=0):
  - take -> main<=skid, go ONE.
  - Otherwise hold both.
- Latency and ordering:
  - Accepted data appears on Output with OutValid on the next cycle (1-cycle latency).
  - Strict FIFO order; no entry duplicated or dropped except by Flush.
- Output stability: while OutValid && !OutReady, Output is stable until taken.
- Producer-side stalls: when InReady=0, InData/InValid are ignored. The producer holds them; no transfer occurs.
- Boundary cases:
  - Simultaneous take and acc in ONE: ordering is kept.
  - Simultaneous take and Flush: Flush wins and the taken entry counts as consumed.
  - Reset mid-transfer: all entries lost.

Optional Feature:
- Macro: SKID_STALL_COUNT_EN.
- With the macro defined:
  - Stalls is a 32-bit counter, reset to 0 by Reset only (not by Flush).
  - Increments each cycle OutValid && !OutReady; wraps 0xFFFFFFFF -> 0.
- Without it:
  - No counter register is built.
  - Stalls is tied to 0.

Test Plan:
- Reset then stream: Reset 2 cycles; push 0x11,0x22,0x33 on consecutive cycles with OutReady=1 -> Output 0x11,0x22,0x33 on cycles 1,2,3 after each accept; InReady stays 1; state never reaches TWO.
- Backpressure fill: OutReady=0; push 0xA,0xB,0xC -> 0xA and 0xB accepted; InReady=0 after the second accept; 0xC is held by the producer; Output stays 0xA.
- Drain after fill: from the previous state raise OutReady -> Output 0xA, 0xB, 0xC in order; InReady returns to 1 one cycle after the first take.
- Flush while TWO: entries 0x5,0x6 buffered; assert Flush with InValid=1, InData=0x7 -> next cycle OutValid=0; 0x7 not accepted (InReady=0 during Flush); the following push of 0x8 is the next Output.
- Reset priority: Reset and Flush together with InValid=1 -> OutValid=0, Output=0 next cycle; no entry retained.
- SKID_STALL_COUNT_EN: hold OutValid=1 with OutReady=0 for 5 cycles -> Stalls=5; Flush leaves Stalls=5; Reset -> Stalls=0; preload to 0xFFFFFFFF and stall one more cycle -> wraps to 0.
